bpu_update_queue: RTL and testbench
===================================

# bpu_update_queue

Parametrised branch-update queue between the EX stage and the branch predictor's update port. It accepts up to two resolved branch records per cycle into a circular FIFO. At the head it merges fetch-pack pairs into a single predictor update, and it presents that update on a registered valid/ready interface. It adds depth/width parametrisation, full-queue backpressure, flush, occupancy reporting and overflow detection.

## Interface
- DEPTH, 8: queue entries; power of two, ≥4.
- PC_WIDTH, 30: word-address PC width.
- BH_WIDTH, 14: branch-history snapshot width.
- META_WIDTH, 20: opaque predictor metadata (pdch, tage history), carried unchanged.
- REC_WIDTH, derived = 3*PC_WIDTH + BH_WIDTH + META_WIDTH + 12: record width.
- Record layout, LSB first: taken_pdc[1], kind_pdc[3], npc_pdc[PC], choice_pdc[2], bh_pdc[BH], taken_ex[1], kind_ex[3], npc_ex[PC], pc_ex[PC], pack_size[1], flush_pre[1], meta[META].
- clk  in  1  sole clock, rising edge.
- rstn  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of queue and output stage.
- in_valid  in  2  per-lane record valid; bit0 is the older lane.
- in_rec_0, in_rec_1  in  REC_WIDTH  lane records.
- in_ready  out  1  high when ≥2 slots are free.
- upd_valid  out  1  update packet valid.
- upd_ready  in  1  predictor accepts the packet.
- upd_rec  out  REC_WIDTH  merged update record.
- upd_ret_pc  out  PC_WIDTH  return address for RAS push.
- count  out  $clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky; set when a write is dropped.

## Operation
- Kind encodings: NOT_JUMP=0, DIRECT_JUMP=1, RET=4, INDIRECT_JUMP=5, CALL=6, JUMP=7.
- Write:
  - Lanes with in_valid set are appended in lane order, 0 then 1.
  - If only lane 1 is valid, it is appended alone.
  - Writes occur only when in_ready=1. Otherwise they are dropped and overflow is set. overflow is cleared only by reset.
- Head packet:
  - Let head entry H0 and next entry H1. Single = H0.pack_size==0 or H0.flush_pre==1.
  - A single packet needs count≥1 and consumes 1 entry.
  - A pair needs count≥2 and consumes 2 entries.
  - A pair with count==1 waits; no partial update is issued.
- Merge for a pair:
  - *_pdc, choice, bh, meta and pc_ex come from H0.
  - taken_ex = H0.taken_ex | H1.taken_ex.
  - npc_ex = H0.taken_ex ? H0.npc_ex : H1.npc_ex.
  - kind_ex priority: DIRECT_JUMP > CALL > RET > INDIRECT_JUMP > NOT_JUMP, taken over both entries. JUMP (7) is treated as NOT_JUMP.
  - Output pack_size=0 and flush_pre=0.
- Single: H0 is passed unchanged.
- upd_ret_pc:
  - Pair with H0.kind_ex≠CALL and H1.kind_ex==CALL: H1.pc_ex+1.
  - Otherwise: H0.pc_ex+1.
  - Arithmetic is modulo 2^PC_WIDTH.
- Output stage:
  - Loads a complete head packet when upd_valid==0 or upd_ready==1. Consumed entries are popped on the same edge.
  - Holds upd_rec and upd_ret_pc stable while upd_valid=1 and upd_ready=0.
- Pointers: read and write pointers wrap modulo DEPTH. count = writes − pops, and never exceeds DEPTH.
- Flush:
  - Empties the queue and clears upd_valid on the next edge.
  - Same-cycle writes and handshakes are discarded; flush wins.
  - overflow is unaffected.

## Timing
- Reset (async assert): pointers=0, count=0, upd_valid=0, upd_rec=0, upd_ret_pc=0, overflow=0, in_ready=1.
  - Reset deasserts synchronously to clk externally.
  - Reset mid-operation discards all contents.
- in_ready is combinational from registered count (DEPTH−count ≥ 2), with no dependency on upd_ready.
- Latency: a record written at edge N can appear on upd_valid after edge N+1, so minimum latency is one cycle from write to valid.
- Simultaneous write and pop in the same cycle: count updates by (writes − pops), range −2..+2.
- Throughput: one update packet per cycle while upd_ready=1 and complete packets are available.
- A full queue with upd_ready held low stalls indefinitely with no loss; only writes attempted while in_ready=0 are lost.

## Test plan
- Reset, then write single record pc_ex=0x100, kind_ex=1, pack_size=0 with upd_ready=1 → upd_valid high the cycle after the write edge; upd_ret_pc=0x101; count returns to 0.
- Write a pair in one cycle: lane0 pack_size=1, taken_ex=0, kind_ex=0; lane1 kind_ex=6, pc_ex=0x204, npc_ex=0x300, taken_ex=1 → one packet with taken_ex=1, kind_ex=6, npc_ex=0x300, pc_ex=lane0's, upd_ret_pc=0x205.
- Pair half written alone (lane0 pack_size=1), then lane1 three cycles later → upd_valid stays 0 until the cycle after the second write, then one merged packet.
- Hold upd_ready=0 and write 8 singles (DEPTH=8), then one more write → in_ready drops at count=7; the dropped write sets overflow=1; upd_rec holds the first record unchanged.
- pack_size=1 with flush_pre=1 on lane0, and lane1 valid → two separate single packets.
- Assert flush while count=5 and upd_valid=1, with a write on the same cycle → next cycle count=0, upd_valid=0, and the write is not stored. Also fill the queue past wrap-around (≥3·DEPTH writes) with random upd_ready and check ordering against a scoreboard.

Source files
------------

// File: rtl/bpu_update_queue.sv
// Branch-update queue between EX and the branch predictor update port.
// Accepts up to two resolved branch records per cycle into a circular FIFO,
// merges fetch-pack pairs at the head into one predictor update, and presents
// the result on a registered valid/ready interface.
//
// Ports:
//   clk, rstn          clock (rising edge), asynchronous active-low reset
//   flush              synchronous clear of the queue and the output stage
//   in_valid[1:0]      per-lane record valid, bit0 is the older lane
//   in_rec_0/1         lane records
//   in_ready           high while at least two slots are free
//   upd_valid/ready    update packet handshake
//   upd_rec            merged update record
//   upd_ret_pc         return address for a RAS push
//   count              current queue occupancy
//   overflow           sticky flag: a write was dropped
module bpu_update_queue #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned PC_WIDTH   = 30,
  parameter int unsigned BH_WIDTH   = 14,
  parameter int unsigned META_WIDTH = 20,
  localparam int unsigned REC_WIDTH = 3 * PC_WIDTH + BH_WIDTH + META_WIDTH + 12,
  localparam int unsigned CNT_WIDTH = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 flush,
  input  logic [1:0]           in_valid,
  input  logic [REC_WIDTH-1:0] in_rec_0,
  input  logic [REC_WIDTH-1:0] in_rec_1,
  output logic                 in_ready,
  output logic                 upd_valid,
  input  logic                 upd_ready,
  output logic [REC_WIDTH-1:0] upd_rec,
  output logic [PC_WIDTH-1:0]  upd_ret_pc,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 overflow
);

  localparam int unsigned PTR_WIDTH = $clog2(DEPTH);

  // Record field offsets, LSB first.
  localparam int unsigned TAKEN_EX_OFF  = 6 + PC_WIDTH + BH_WIDTH;
  localparam int unsigned KIND_EX_OFF   = TAKEN_EX_OFF + 1;
  localparam int unsigned NPC_EX_OFF    = KIND_EX_OFF + 3;
  localparam int unsigned PC_EX_OFF     = NPC_EX_OFF + PC_WIDTH;
  localparam int unsigned PACK_SIZE_OFF = PC_EX_OFF + PC_WIDTH;
  localparam int unsigned FLUSH_PRE_OFF = PACK_SIZE_OFF + 1;

  localparam logic [2:0] KIND_NOT_JUMP = 3'd0;
  localparam logic [2:0] KIND_DIRECT   = 3'd1;
  localparam logic [2:0] KIND_RET      = 3'd4;
  localparam logic [2:0] KIND_INDIRECT = 3'd5;
  localparam logic [2:0] KIND_CALL     = 3'd6;

  // Combined branch kind of a pair; JUMP and unused codes fall to NOT_JUMP.
  function automatic logic [2:0] merge_kind(input logic [2:0] a, input logic [2:0] b);
    if (a == KIND_DIRECT || b == KIND_DIRECT)          merge_kind = KIND_DIRECT;
    else if (a == KIND_CALL || b == KIND_CALL)         merge_kind = KIND_CALL;
    else if (a == KIND_RET || b == KIND_RET)           merge_kind = KIND_RET;
    else if (a == KIND_INDIRECT || b == KIND_INDIRECT) merge_kind = KIND_INDIRECT;
    else                                               merge_kind = KIND_NOT_JUMP;
  endfunction

  logic [REC_WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr;
  logic [PTR_WIDTH-1:0] rd_ptr;
  logic [PTR_WIDTH-1:0] wr_ptr_n1;
  logic [PTR_WIDTH-1:0] rd_ptr_n1;
  logic [CNT_WIDTH-1:0] free_slots;
  logic [CNT_WIDTH-1:0] n_wr;
  logic [CNT_WIDTH-1:0] n_pop;
  logic                 wr_go;
  logic                 wr_drop;

  logic [REC_WIDTH-1:0] h0;
  logic [2:0]           h0_kind;
  logic [PC_WIDTH-1:0]  h0_pc;
  logic                 h0_taken;
  logic [2:0]           h1_kind;
  logic [PC_WIDTH-1:0]  h1_pc;
  logic [PC_WIDTH-1:0]  h1_npc;
  logic                 h1_taken;
  logic                 is_single;
  logic                 pkt_avail;
  logic                 load_ok;
  logic                 pop_go;
  logic [REC_WIDTH-1:0] pkt_rec;
  logic [PC_WIDTH-1:0]  pkt_ret;

  assign wr_ptr_n1  = wr_ptr + PTR_WIDTH'(1);
  assign rd_ptr_n1  = rd_ptr + PTR_WIDTH'(1);

  // Space check uses registered occupancy only, never the output handshake.
  assign free_slots = CNT_WIDTH'(DEPTH) - count;
  assign in_ready   = (free_slots >= CNT_WIDTH'(2));

  assign wr_go   = in_ready && (|in_valid) && !flush;
  assign wr_drop = !in_ready && (|in_valid) && !flush;
  assign n_wr    = wr_go ? (CNT_WIDTH'(in_valid[0]) + CNT_WIDTH'(in_valid[1])) : '0;

  // Head entries; H1 fields are only meaningful when count >= 2.
  assign h0       = mem[rd_ptr];
  assign h0_kind  = h0[KIND_EX_OFF +: 3];
  assign h0_pc    = h0[PC_EX_OFF +: PC_WIDTH];
  assign h0_taken = h0[TAKEN_EX_OFF];
  assign h1_kind  = mem[rd_ptr_n1][KIND_EX_OFF +: 3];
  assign h1_pc    = mem[rd_ptr_n1][PC_EX_OFF +: PC_WIDTH];
  assign h1_npc   = mem[rd_ptr_n1][NPC_EX_OFF +: PC_WIDTH];
  assign h1_taken = mem[rd_ptr_n1][TAKEN_EX_OFF];

  assign is_single = !h0[PACK_SIZE_OFF] || h0[FLUSH_PRE_OFF];
  // A pair with only its first half queued waits for the second half.
  assign pkt_avail = is_single ? (count >= CNT_WIDTH'(1)) : (count >= CNT_WIDTH'(2));
  assign load_ok   = (!upd_valid || upd_ready) && !flush;
  assign pop_go    = load_ok && pkt_avail;
  assign n_pop     = pop_go ? (is_single ? CNT_WIDTH'(1) : CNT_WIDTH'(2)) : '0;

  // Build the head packet: single passes H0 through, pair merges EX fields.
  always_comb begin
    pkt_rec = h0;
    pkt_ret = h0_pc + PC_WIDTH'(1);
    if (!is_single) begin
      pkt_rec[TAKEN_EX_OFF]            = h0_taken | h1_taken;
      pkt_rec[KIND_EX_OFF +: 3]        = merge_kind(h0_kind, h1_kind);
      pkt_rec[NPC_EX_OFF +: PC_WIDTH]  = h0_taken ? h0[NPC_EX_OFF +: PC_WIDTH] : h1_npc;
      pkt_rec[PACK_SIZE_OFF]           = 1'b0;
      pkt_rec[FLUSH_PRE_OFF]           = 1'b0;
      if (h0_kind != KIND_CALL && h1_kind == KIND_CALL) begin
        pkt_ret = h1_pc + PC_WIDTH'(1);
      end
    end
  end

  // Queue storage; lane 1 takes the slot after lane 0 only when both write.
  always_ff @(posedge clk) begin
    if (wr_go) begin
      if (in_valid[0]) mem[wr_ptr] <= in_rec_0;
      if (in_valid[1]) mem[in_valid[0] ? wr_ptr_n1 : wr_ptr] <= in_rec_1;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_WIDTH'(n_wr);
      rd_ptr <= rd_ptr + PTR_WIDTH'(n_pop);
      count  <= count + n_wr - n_pop;
    end
  end

  // Sticky drop flag; only reset clears it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overflow <= 1'b0;
    end else if (wr_drop) begin
      overflow <= 1'b1;
    end
  end

  // Output stage: reload when empty or being accepted, otherwise hold.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      upd_valid  <= 1'b0;
      upd_rec    <= '0;
      upd_ret_pc <= '0;
    end else if (flush) begin
      upd_valid <= 1'b0;
    end else if (load_ok) begin
      upd_valid <= pkt_avail;
      if (pkt_avail) begin
        upd_rec    <= pkt_rec;
        upd_ret_pc <= pkt_ret;
      end
    end
  end

endmodule

// File: tb/tb_bpu_update_queue.sv
// Self-checking bench for bpu_update_queue: directed steps followed by a
// randomized phase, all checked against a queue-based reference model.
module tb_bpu_update_queue;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned PCW   = 30;
  localparam int unsigned BHW   = 14;
  localparam int unsigned MW    = 20;
  localparam int unsigned RW    = 3 * PCW + BHW + MW + 12;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  localparam int unsigned O_TEX  = 6 + PCW + BHW;
  localparam int unsigned O_KEX  = O_TEX + 1;
  localparam int unsigned O_NEX  = O_KEX + 3;
  localparam int unsigned O_PCX  = O_NEX + PCW;
  localparam int unsigned O_PS   = O_PCX + PCW;
  localparam int unsigned O_FP   = O_PS + 1;
  localparam int unsigned O_META = O_FP + 1;

  typedef logic [RW-1:0] rec_t;

  logic           clk = 1'b0;
  logic           rstn;
  logic           flush;
  logic [1:0]     in_valid;
  rec_t           in_rec_0;
  rec_t           in_rec_1;
  logic           in_ready;
  logic           upd_valid;
  logic           upd_ready;
  rec_t           upd_rec;
  logic [PCW-1:0] upd_ret_pc;
  logic [CW-1:0]  count;
  logic           overflow;

  bpu_update_queue #(
    .DEPTH(DEPTH), .PC_WIDTH(PCW), .BH_WIDTH(BHW), .META_WIDTH(MW)
  ) dut (
    .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid),
    .in_rec_0(in_rec_0), .in_rec_1(in_rec_1), .in_ready(in_ready),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_rec(upd_rec),
    .upd_ret_pc(upd_ret_pc), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state.
  rec_t           q[$];
  logic           m_valid;
  logic           m_ovf;
  rec_t           m_rec;
  logic [PCW-1:0] m_ret;

  function automatic logic [PCW-1:0] f_pc(input rec_t r);
    return r[O_PCX +: PCW];
  endfunction
  function automatic logic [PCW-1:0] f_npc(input rec_t r);
    return r[O_NEX +: PCW];
  endfunction
  function automatic logic [2:0] f_kind(input rec_t r);
    return r[O_KEX +: 3];
  endfunction

  // Branch kind priority: DIRECT_JUMP, CALL, RET, INDIRECT_JUMP, else NOT_JUMP.
  function automatic logic [2:0] prio_kind(input logic [2:0] a, input logic [2:0] b);
    logic [11:0] order;
    order = {3'd5, 3'd4, 3'd6, 3'd1};
    for (int i = 0; i < 4; i++) begin
      if (a == order[i*3 +: 3] || b == order[i*3 +: 3]) return order[i*3 +: 3];
    end
    return 3'd0;
  endfunction

  function automatic rec_t mk(input logic [PCW-1:0] pc, input logic [2:0] kind,
                              input logic taken, input logic [PCW-1:0] npc,
                              input logic ps, input logic fp);
    logic [MW-1:0]  meta;
    logic [BHW-1:0] bh;
    logic [1:0]     choice;
    logic [PCW-1:0] npc_pdc;
    logic [2:0]     kind_pdc;
    logic           taken_pdc;
    meta      = MW'($urandom);
    bh        = BHW'($urandom);
    choice    = 2'($urandom);
    npc_pdc   = PCW'($urandom);
    kind_pdc  = 3'($urandom);
    taken_pdc = 1'($urandom);
    return {meta, fp, ps, pc, npc, kind, taken, bh, choice, npc_pdc, kind_pdc, taken_pdc};
  endfunction

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Packet the head of the model queue would produce, if complete.
  task automatic model_head(output logic ok, output int n, output rec_t r,
                            output logic [PCW-1:0] ret);
    rec_t h0;
    rec_t h1;
    ok = 1'b0; n = 0; r = '0; ret = '0;
    if (q.size() == 0) return;
    h0 = q[0];
    if (!h0[O_PS] || h0[O_FP]) begin
      ok = 1'b1; n = 1; r = h0; ret = f_pc(h0) + PCW'(1);
    end else if (q.size() >= 2) begin
      h1 = q[1];
      r = {h0[O_META +: MW], 1'b0, 1'b0, f_pc(h0),
           (h0[O_TEX] ? f_npc(h0) : f_npc(h1)),
           prio_kind(f_kind(h0), f_kind(h1)),
           (h0[O_TEX] | h1[O_TEX]),
           h0[O_TEX-1:0]};
      ret = (f_kind(h0) != 3'd6 && f_kind(h1) == 3'd6) ? f_pc(h1) + PCW'(1)
                                                       : f_pc(h0) + PCW'(1);
      ok = 1'b1; n = 2;
    end
  endtask

  // Advance the model across one clock edge with the given inputs.
  task automatic model_edge(input logic [1:0] v, input rec_t r0, input rec_t r1,
                            input logic rdy, input logic fl);
    int             size_pre;
    logic           ok;
    int             n;
    rec_t           r;
    logic [PCW-1:0] ret;
    size_pre = q.size();
    if (fl) begin
      q.delete();
      m_valid = 1'b0;
      return;
    end
    if (!m_valid || rdy) begin
      model_head(ok, n, r, ret);
      m_valid = ok;
      if (ok) begin
        m_rec = r;
        m_ret = ret;
        repeat (n) void'(q.pop_front());
      end
    end
    if (v != 2'b00) begin
      if (int'(DEPTH) - size_pre >= 2) begin
        if (v[0]) q.push_back(r0);
        if (v[1]) q.push_back(r1);
      end else begin
        m_ovf = 1'b1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, 160'(upd_valid), 160'(m_valid));
    chk({tag, ".count"}, 160'(count), 160'(q.size()));
    chk({tag, ".in_ready"}, 160'(in_ready), 160'((int'(DEPTH) - q.size()) >= 2));
    chk({tag, ".overflow"}, 160'(overflow), 160'(m_ovf));
    if (m_valid) begin
      chk({tag, ".rec"}, 160'(upd_rec), 160'(m_rec));
      chk({tag, ".ret"}, 160'(upd_ret_pc), 160'(m_ret));
    end
  endtask

  task automatic step(input string tag, input logic [1:0] v, input rec_t r0,
                      input rec_t r1, input logic rdy, input logic fl);
    in_valid  = v;
    in_rec_0  = r0;
    in_rec_1  = r1;
    upd_ready = rdy;
    flush     = fl;
    model_edge(v, r0, r1, rdy, fl);
    @(posedge clk);
    #1;
    in_valid = 2'b00;
    flush    = 1'b0;
    check_all(tag);
  endtask

  task automatic idle(input string tag, input logic rdy);
    step(tag, 2'b00, '0, '0, rdy, 1'b0);
  endtask

  task automatic model_reset();
    q.delete();
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_rec   = '0;
    m_ret   = '0;
  endtask

  initial begin
    rec_t       a;
    rec_t       r0;
    rec_t       r1;
    logic [1:0] v;

    rstn = 1'b0; flush = 1'b0; in_valid = 2'b00; upd_ready = 1'b0;
    in_rec_0 = '0; in_rec_1 = '0;
    model_reset();

    // Reset values.
    #12;
    chk("rst.valid", 160'(upd_valid), 160'(0));
    chk("rst.count", 160'(count), 160'(0));
    chk("rst.in_ready", 160'(in_ready), 160'(1));
    chk("rst.overflow", 160'(overflow), 160'(0));
    chk("rst.rec", 160'(upd_rec), 160'(0));
    chk("rst.ret", 160'(upd_ret_pc), 160'(0));
    @(negedge clk);
    rstn = 1'b1;

    // Single record, one-cycle latency.
    a = mk(30'h100, 3'd1, 1'b1, 30'h180, 1'b0, 1'b0);
    step("t1w", 2'b01, a, '0, 1'b1, 1'b0);
    chk("t1.valid_lat", 160'(upd_valid), 160'(0));
    idle("t1o", 1'b1);
    chk("t1.valid", 160'(upd_valid), 160'(1));
    chk("t1.ret", 160'(upd_ret_pc), 160'(30'h101));
    chk("t1.count", 160'(count), 160'(0));
    idle("t1d", 1'b1);

    // Pair in one cycle.
    r0 = mk(30'h200, 3'd0, 1'b0, 30'h250, 1'b1, 1'b0);
    r1 = mk(30'h204, 3'd6, 1'b1, 30'h300, 1'b0, 1'b0);
    step("t2w", 2'b11, r0, r1, 1'b1, 1'b0);
    idle("t2o", 1'b1);
    chk("t2.kind", 160'(upd_rec[O_KEX +: 3]), 160'(3'd6));
    chk("t2.taken", 160'(upd_rec[O_TEX]), 160'(1));
    chk("t2.npc", 160'(upd_rec[O_NEX +: PCW]), 160'(30'h300));
    chk("t2.pc", 160'(upd_rec[O_PCX +: PCW]), 160'(30'h200));
    chk("t2.ret", 160'(upd_ret_pc), 160'(30'h205));
    idle("t2d", 1'b1);

    // Pair half written alone, second half three cycles later on lane 1.
    r0 = mk(30'h400, 3'd0, 1'b1, 30'h410, 1'b1, 1'b0);
    r1 = mk(30'h401, 3'd4, 1'b0, 30'h420, 1'b0, 1'b0);
    step("t3a", 2'b01, r0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle("t3wait", 1'b1);
      chk("t3.hold", 160'(upd_valid), 160'(0));
    end
    step("t3b", 2'b10, '0, r1, 1'b1, 1'b0);
    chk("t3.lat", 160'(upd_valid), 160'(0));
    idle("t3o", 1'b1);
    chk("t3.kind", 160'(upd_rec[O_KEX +: 3]), 160'(3'd4));
    chk("t3.npc", 160'(upd_rec[O_NEX +: PCW]), 160'(30'h410));
    chk("t3.ret", 160'(upd_ret_pc), 160'(30'h401));
    idle("t3d", 1'b1);

    // Fill with upd_ready low, then one dropped write.
    for (int i = 0; i < 8; i++) begin
      r0 = mk(PCW'(32'h600 + 32'(i)), 3'd0, 1'b0, 30'h0, 1'b0, 1'b0);
      if (i == 0) a = r0;
      step("t4w", 2'b01, r0, '0, 1'b0, 1'b0);
    end
    chk("t4.count7", 160'(count), 160'(7));
    chk("t4.in_ready", 160'(in_ready), 160'(0));
    chk("t4.ovf0", 160'(overflow), 160'(0));
    step("t4drop", 2'b01, mk(30'h6ff, 3'd0, 1'b0, 30'h0, 1'b0, 1'b0), '0, 1'b0, 1'b0);
    chk("t4.ovf1", 160'(overflow), 160'(1));
    chk("t4.count", 160'(count), 160'(7));
    chk("t4.hold", 160'(upd_rec), 160'(a));
    for (int i = 0; i < 9; i++) idle("t4drain", 1'b1);
    chk("t4.empty", 160'(count), 160'(0));

    // pack_size with flush_pre forces two singles.
    r0 = mk(30'h500, 3'd6, 1'b1, 30'h600, 1'b1, 1'b1);
    r1 = mk(30'h501, 3'd0, 1'b0, 30'h502, 1'b0, 1'b0);
    step("t5w", 2'b11, r0, r1, 1'b1, 1'b0);
    idle("t5a", 1'b1);
    chk("t5.rec0", 160'(upd_rec), 160'(r0));
    chk("t5.ret0", 160'(upd_ret_pc), 160'(30'h501));
    idle("t5b", 1'b1);
    chk("t5.rec1", 160'(upd_rec), 160'(r1));
    chk("t5.ret1", 160'(upd_ret_pc), 160'(30'h502));
    idle("t5d", 1'b1);

    // Flush with count 5, upd_valid high and a same-cycle write.
    for (int i = 0; i < 6; i++) begin
      step("t6w", 2'b01, mk(PCW'(32'h700 + 32'(i)), 3'd0, 1'b0, 30'h0, 1'b0, 1'b0),
           '0, 1'b0, 1'b0);
    end
    chk("t6.pre_count", 160'(count), 160'(5));
    chk("t6.pre_valid", 160'(upd_valid), 160'(1));
    step("t6f", 2'b11, mk(30'h7f0, 3'd1, 1'b0, 30'h0, 1'b0, 1'b0),
         mk(30'h7f1, 3'd1, 1'b0, 30'h0, 1'b0, 1'b0), 1'b1, 1'b1);
    chk("t6.count", 160'(count), 160'(0));
    chk("t6.valid", 160'(upd_valid), 160'(0));
    idle("t6n", 1'b1);
    chk("t6.nostore", 160'(count), 160'(0));

    // Randomized traffic with wrap-around, backpressure and rare flushes.
    for (int i = 0; i < 400; i++) begin
      v  = 2'($urandom);
      r0 = mk(PCW'($urandom), 3'($urandom), 1'($urandom), PCW'($urandom),
              1'($urandom), ($urandom_range(0, 3) == 0));
      r1 = mk(PCW'($urandom), 3'($urandom), 1'($urandom), PCW'($urandom),
              1'($urandom), ($urandom_range(0, 3) == 0));
      step("rnd", v, r0, r1,
           (i < 200) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 79) == 0));
    end

    // Reset mid-operation discards everything, including the sticky flag.
    step("t7w", 2'b11, mk(30'h800, 3'd0, 1'b0, 30'h0, 1'b0, 1'b0),
         mk(30'h801, 3'd0, 1'b0, 30'h0, 1'b0, 1'b0), 1'b0, 1'b0);
    #2;
    rstn = 1'b0;
    #1;
    model_reset();
    chk("t7.count", 160'(count), 160'(0));
    chk("t7.valid", 160'(upd_valid), 160'(0));
    chk("t7.ovf", 160'(overflow), 160'(0));
    chk("t7.in_ready", 160'(in_ready), 160'(1));
    chk("t7.rec", 160'(upd_rec), 160'(0));
    @(negedge clk);
    rstn = 1'b1;
    a = mk(30'h900, 3'd7, 1'b0, 30'h0, 1'b0, 1'b0);
    step("t7a", 2'b01, a, '0, 1'b1, 1'b0);
    idle("t7b", 1'b1);
    chk("t7.after", 160'(upd_rec), 160'(a));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
